pipe_register_file: RTL and testbench
=====================================

PIPE_REGISTER_FILE -- requirements
Module: pipe_register_file

Interface
REQ-001 Parameter DATA_W, 32, register data width in bits.
REQ-002 Parameter NREGS, 32, number of architectural registers; power of two, >= 2.
REQ-003 Parameter NRD, 2, number of read ports.
REQ-004 Parameter NWR, 2, number of write ports.
REQ-005 Localparam SEL_W = $clog2(NREGS), register select width.
REQ-006 CLK  in  1  clock; all state updates on rising edge.
REQ-007 nRST  in  1  reset, asynchronous, active-low.
REQ-008 rsel  in  NRD x SEL_W  read select per port.
REQ-009 rdat  out  NRD x DATA_W  read data per port.
REQ-010 rbusy  out  NRD  1 = register on that read port has a pending write (scoreboard hit).
REQ-011 WEN  in  NWR  write enable per write port.
REQ-012 wsel  in  NWR x SEL_W  write select per port.
REQ-013 wdat  in  NWR x DATA_W  write data per port.
REQ-014 issue_en  in  1  mark register issue_sel pending.
REQ-015 issue_sel  in  SEL_W  destination of the issued instruction.
REQ-016 flush  in  1  clear all pending marks.

Function
REQ-017 Register 0 SHALL always read 0; writes to it SHALL be discarded; it SHALL never be marked pending.
REQ-018 Writes SHALL commit on the rising edge when WEN[i]=1; registers not written SHALL hold.
REQ-019 Two ports writing the same register in one cycle: highest-index port SHALL win.
REQ-020 Read SHALL be combinational with write-through bypass: if rsel[k] matches an enabled wsel[i] (non-zero), rdat[k] SHALL be that cycle's wdat (winning port per REQ-019); otherwise stored value.
REQ-021 Scoreboard: one pending bit per register; issue_en SHALL set pending[issue_sel] at the next edge.
REQ-022 Enabled write to register r SHALL clear pending[r] at the next edge.
REQ-023 Issue and write to the same register in the same cycle: pending SHALL end set (issue is newer).
REQ-024 flush SHALL clear every pending bit at the next edge and take priority over issue_en in that cycle; register writes in that cycle SHALL still commit.
REQ-025 rbusy[k] SHALL equal pending[rsel[k]] AND NOT (write to rsel[k] enabled this cycle), i.e. writeback bypasses the busy indication; rbusy for register 0 SHALL be 0.
REQ-026 No multi-cycle latency: read 0 cycles, write/scoreboard update 1 cycle.

Reset
REQ-027 nRST low SHALL immediately clear all registers and all pending bits regardless of CLK.
REQ-028 During reset rdat SHALL be 0 on all ports and rbusy SHALL be 0 (bypass SHALL be suppressed while nRST=0).
REQ-029 Reset asserted mid-operation SHALL discard any same-cycle write or issue.

Structure
REQ-030 word_t, regbits_t and default DATA_W/NREGS constants SHALL live in cpu_types_pkg; module parameters default from them.
REQ-031 Scoreboard SHALL be a separate sub-module reg_scoreboard (issue/writeback/flush/query) instantiated once.
REQ-032 Read ports and bypass SHALL be generated per port with a generate loop; no port-specific hand code.

Verification
REQ-033 Reset then read all 32 registers on both ports -> all rdat = 0, rbusy = 0.
REQ-034 WEN[0]=1 wsel=5 wdat=0xDEADBEEF, rsel[0]=5 same cycle -> rdat[0]=0xDEADBEEF same cycle and after edge; write wsel=0 wdat=0x1234 -> r0 reads 0.
REQ-035 Both ports write r7 (0x11, 0x22) same cycle -> r7 = 0x22; bypass also shows 0x22.
REQ-036 issue r9, next cycle rsel=9 -> rbusy=1; WEN writes r9=0x55 -> rbusy=0 that cycle, pending clear after edge; issue+write r9 same cycle -> rbusy=1 after edge.
REQ-037 Issue r3, r4, r6, then flush with issue_en=1 issue_sel=8 -> all rbusy 0 including r8.
REQ-038 Parameter sweep NREGS=16, DATA_W=64, NRD=3, NWR=1 rerunning REQ-034..REQ-036 -> identical pass.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types and default register-file geometry.
package cpu_types_pkg;

  localparam int unsigned DEF_DATA_W = 32;
  localparam int unsigned DEF_NREGS  = 32;
  localparam int unsigned DEF_NRD    = 2;
  localparam int unsigned DEF_NWR    = 2;

  typedef logic [DEF_DATA_W-1:0] word_t;
  typedef logic [DEF_NREGS-1:0]  regbits_t;

endpackage

// File: rtl/pipe_register_file_if.sv
// Register-file bundle: read ports, write ports and issue/flush controls.
interface pipe_register_file_if
  import cpu_types_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned NREGS  = DEF_NREGS,
  parameter int unsigned NRD    = DEF_NRD,
  parameter int unsigned NWR    = DEF_NWR
);
  localparam int unsigned SEL_W = $clog2(NREGS);

  logic [NRD-1:0][SEL_W-1:0]  rsel;
  logic [NRD-1:0][DATA_W-1:0] rdat;
  logic [NRD-1:0]             rbusy;
  logic [NWR-1:0]             WEN;
  logic [NWR-1:0][SEL_W-1:0]  wsel;
  logic [NWR-1:0][DATA_W-1:0] wdat;
  logic                       issue_en;
  logic [SEL_W-1:0]           issue_sel;
  logic                       flush;

  modport master (
    output rsel, WEN, wsel, wdat, issue_en, issue_sel, flush,
    input  rdat, rbusy
  );

  modport slave (
    input  rsel, WEN, wsel, wdat, issue_en, issue_sel, flush,
    output rdat, rbusy
  );
endinterface

// File: rtl/reg_scoreboard.sv
// Pending-write scoreboard: one bit per register, set on issue, cleared on writeback or flush.
module reg_scoreboard
  import cpu_types_pkg::*;
#(
  parameter int unsigned NREGS = DEF_NREGS,
  parameter int unsigned NRD   = DEF_NRD,
  localparam int unsigned SEL_W = $clog2(NREGS)
) (
  input  logic                     CLK,
  input  logic                     nRST,
  input  logic                     issue_en_i,
  input  logic [SEL_W-1:0]         issue_sel_i,
  input  logic                     flush_i,
  input  logic [NREGS-1:0]         wb_mask_i,
  input  logic [NRD-1:0][SEL_W-1:0] qsel_i,
  output logic [NRD-1:0]           qbusy_c_o
);

  logic [NREGS-1:0] pend_q;
  logic [NREGS-1:0] pend_d;

  // Issue is newer than a same-cycle writeback; flush overrides both.
  always_comb begin
    pend_d = pend_q & ~wb_mask_i;
    if (issue_en_i) begin
      pend_d[issue_sel_i] = 1'b1;
    end
    if (flush_i) begin
      pend_d = '0;
    end
    pend_d[0] = 1'b0;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      pend_q <= '0;
    end else begin
      pend_q <= pend_d;
    end
  end

  // A writeback in flight this cycle hides the pending mark.
  for (genvar k = 0; k < NRD; k++) begin : g_q
    assign qbusy_c_o[k] = pend_q[qsel_i[k]] & ~wb_mask_i[qsel_i[k]];
  end

endmodule

// File: rtl/pipe_register_file.sv
// Multi-port register file with write-through bypass and pending-write scoreboard.
module pipe_register_file
  import cpu_types_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned NREGS  = DEF_NREGS,
  parameter int unsigned NRD    = DEF_NRD,
  parameter int unsigned NWR    = DEF_NWR
) (
  input  logic CLK,
  input  logic nRST,
  pipe_register_file_if.slave rf
);
  localparam int unsigned SEL_W = $clog2(NREGS);

  logic [DATA_W-1:0] regs_q [NREGS];
  logic [DATA_W-1:0] regs_d [NREGS];
  logic [NREGS-1:0]  wr_mask_c;
  logic [NRD-1:0]    busy_c;

  // Write decode; later ports override earlier ones, r0 is never written.
  always_comb begin
    regs_d    = regs_q;
    wr_mask_c = '0;
    for (int unsigned r = 1; r < NREGS; r++) begin
      for (int unsigned i = 0; i < NWR; i++) begin
        if (rf.WEN[i] && (rf.wsel[i] == SEL_W'(r))) begin
          regs_d[r]    = rf.wdat[i];
          wr_mask_c[r] = 1'b1;
        end
      end
    end
    regs_d[0] = '0;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int unsigned r = 0; r < NREGS; r++) begin
        regs_q[r] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  reg_scoreboard #(
    .NREGS (NREGS),
    .NRD   (NRD)
  ) u_sb (
    .CLK         (CLK),
    .nRST        (nRST),
    .issue_en_i  (rf.issue_en),
    .issue_sel_i (rf.issue_sel),
    .flush_i     (rf.flush),
    .wb_mask_i   (wr_mask_c),
    .qsel_i      (rf.rsel),
    .qbusy_c_o   (busy_c)
  );

  // Per-port read with bypass; reset forces zero so in-flight writes never leak out.
  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [DATA_W-1:0] rd_c;

    always_comb begin
      rd_c = regs_q[rf.rsel[k]];
      for (int unsigned i = 0; i < NWR; i++) begin
        if (rf.WEN[i] && (rf.wsel[i] == rf.rsel[k]) && (rf.rsel[k] != '0)) begin
          rd_c = rf.wdat[i];
        end
      end
      if (!nRST) begin
        rd_c = '0;
      end
    end

    assign rf.rdat[k]  = rd_c;
    assign rf.rbusy[k] = busy_c[k];
  end

endmodule

// File: tb/tb_pipe_register_file.sv
// Scoreboard bench for pipe_register_file: default geometry plus a 16x64, 3R/1W variant.
module tb_pipe_register_file;
  import cpu_types_pkg::*;

  logic CLK = 1'b0;
  logic nRST;

  always #5 CLK = ~CLK;

  pipe_register_file_if #(.DATA_W(32), .NREGS(32), .NRD(2), .NWR(2)) ifa ();
  pipe_register_file_if #(.DATA_W(64), .NREGS(16), .NRD(3), .NWR(1)) ifb ();

  pipe_register_file #(.DATA_W(32), .NREGS(32), .NRD(2), .NWR(2)) dut_a (
    .CLK  (CLK),
    .nRST (nRST),
    .rf   (ifa)
  );

  pipe_register_file #(.DATA_W(64), .NREGS(16), .NRD(3), .NWR(1)) dut_b (
    .CLK  (CLK),
    .nRST (nRST),
    .rf   (ifb)
  );

  typedef struct {
    int          dut;
    int          port;
    logic [63:0] dat;
    logic        busy;
    string       name;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  exp_t        e;
  logic [63:0] act_d;
  logic        act_b;

  // Monitor: every expectation queued for this cycle is checked at the falling edge.
  always @(negedge CLK) begin
    while (q.size() > 0) begin
      e = q.pop_front();
      if (e.dut == 0) begin
        act_d = 64'(ifa.rdat[e.port]);
        act_b = ifa.rbusy[e.port];
      end else begin
        act_d = ifb.rdat[e.port];
        act_b = ifb.rbusy[e.port];
      end
      n_tests++;
      if (act_d !== e.dat) begin
        n_fail++;
        $display("FAIL %s dut%0d port%0d rdat: got %h expected %h", e.name, e.dut, e.port, act_d, e.dat);
      end
      n_tests++;
      if (act_b !== e.busy) begin
        n_fail++;
        $display("FAIL %s dut%0d port%0d rbusy: got %b expected %b", e.name, e.dut, e.port, act_b, e.busy);
      end
    end
  end

  task automatic push_exp(input int dut, input int port, input logic [63:0] dat,
                          input logic busy, input string name);
    exp_t x;
    x.dut  = dut;
    x.port = port;
    x.dat  = dat;
    x.busy = busy;
    x.name = name;
    q.push_back(x);
  endtask

  task automatic idle();
    ifa.rsel = '0; ifa.WEN = '0; ifa.wsel = '0; ifa.wdat = '0;
    ifa.issue_en = 1'b0; ifa.issue_sel = '0; ifa.flush = 1'b0;
    ifb.rsel = '0; ifb.WEN = '0; ifb.wsel = '0; ifb.wdat = '0;
    ifb.issue_en = 1'b0; ifb.issue_sel = '0; ifb.flush = 1'b0;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic rd(input int dut, input int port, input int r);
    if (dut == 0) ifa.rsel[port] = 5'(r);
    else          ifb.rsel[port] = 4'(r);
  endtask

  task automatic wr(input int dut, input int port, input int r, input logic [63:0] d);
    if (dut == 0) begin
      ifa.WEN[port] = 1'b1; ifa.wsel[port] = 5'(r); ifa.wdat[port] = d[31:0];
    end else begin
      ifb.WEN[port] = 1'b1; ifb.wsel[port] = 4'(r); ifb.wdat[port] = d;
    end
  endtask

  task automatic issue(input int dut, input int r);
    if (dut == 0) begin ifa.issue_en = 1'b1; ifa.issue_sel = 5'(r); end
    else          begin ifb.issue_en = 1'b1; ifb.issue_sel = 4'(r); end
  endtask

  task automatic do_flush(input int dut);
    if (dut == 0) ifa.flush = 1'b1;
    else          ifb.flush = 1'b1;
  endtask

  task automatic suite(input int d);
    logic [63:0] big;
    big = (d == 0) ? 64'h0000_0000_DEAD_BEEF : 64'hCAFE_0000_DEAD_BEEF;

    // Write with same-cycle bypass, then r0 discard.
    idle(); wr(d, 0, 5, big); rd(d, 0, 5); rd(d, 1, 5);
    push_exp(d, 0, big, 1'b0, "wr_bypass"); push_exp(d, 1, big, 1'b0, "wr_bypass_p1"); tick();
    idle(); wr(d, 0, 0, 64'h1234); rd(d, 0, 0); rd(d, 1, 5);
    push_exp(d, 0, 64'h0, 1'b0, "r0_bypass"); push_exp(d, 1, big, 1'b0, "wr_commit"); tick();
    idle(); rd(d, 0, 0); push_exp(d, 0, 64'h0, 1'b0, "r0_discard"); tick();

    // Same-register collision: highest port wins (single-port variant just writes 0x22).
    idle(); wr(d, 0, 7, 64'h11);
    if (d == 0) wr(d, 1, 7, 64'h22);
    else        wr(d, 0, 7, 64'h22);
    rd(d, 0, 7); push_exp(d, 0, 64'h22, 1'b0, "dual_wr_bypass"); tick();
    idle(); rd(d, 0, 7); push_exp(d, 0, 64'h22, 1'b0, "dual_wr_commit");
    if (d == 0) begin
      wr(0, 0, 10, 64'hA); wr(0, 1, 11, 64'hB); rd(0, 1, 11);
      push_exp(0, 1, 64'hB, 1'b0, "split_wr_bypass");
    end
    tick();
    if (d == 0) begin
      idle(); rd(0, 0, 10); rd(0, 1, 11);
      push_exp(0, 0, 64'hA, 1'b0, "split_wr_p0"); push_exp(0, 1, 64'hB, 1'b0, "split_wr_p1"); tick();
    end

    // Scoreboard: issue, writeback bypass, issue vs write ordering, r0 never pending.
    idle(); issue(d, 9); rd(d, 0, 9); push_exp(d, 0, 64'h0, 1'b0, "issue_not_yet"); tick();
    idle(); rd(d, 0, 9); push_exp(d, 0, 64'h0, 1'b1, "issue_busy"); tick();
    idle(); wr(d, 0, 9, 64'h55); rd(d, 0, 9); rd(d, 1, 9);
    push_exp(d, 0, 64'h55, 1'b0, "wb_hides_busy"); push_exp(d, 1, 64'h55, 1'b0, "wb_hides_busy_p1"); tick();
    idle(); rd(d, 0, 9); push_exp(d, 0, 64'h55, 1'b0, "wb_clears"); tick();
    idle(); issue(d, 9); wr(d, 0, 9, 64'h66); rd(d, 0, 9);
    push_exp(d, 0, 64'h66, 1'b0, "issue_wr_same"); tick();
    idle(); rd(d, 0, 9); push_exp(d, 0, 64'h66, 1'b1, "issue_wins"); tick();
    idle(); issue(d, 0); tick();
    idle(); rd(d, 0, 0); push_exp(d, 0, 64'h0, 1'b0, "r0_never_busy"); tick();

    // Flush beats a same-cycle issue; the same-cycle write still commits.
    idle(); issue(d, 3); tick();
    idle(); issue(d, 4); tick();
    idle(); issue(d, 6); rd(d, 0, 3); rd(d, 1, 4);
    push_exp(d, 0, 64'h0, 1'b1, "pend3"); push_exp(d, 1, 64'h0, 1'b1, "pend4"); tick();
    idle(); do_flush(d); issue(d, 8); wr(d, 0, 12, 64'h77); rd(d, 0, 6); rd(d, 1, 5);
    push_exp(d, 0, 64'h0, 1'b1, "pend6"); push_exp(d, 1, big, 1'b0, "hold5"); tick();
    idle(); rd(d, 0, 3); rd(d, 1, 4);
    push_exp(d, 0, 64'h0, 1'b0, "flush3"); push_exp(d, 1, 64'h0, 1'b0, "flush4"); tick();
    idle(); rd(d, 0, 6); rd(d, 1, 8);
    push_exp(d, 0, 64'h0, 1'b0, "flush6"); push_exp(d, 1, 64'h0, 1'b0, "flush8_issue_dropped"); tick();
    idle(); rd(d, 0, 12); rd(d, 1, 9);
    push_exp(d, 0, 64'h77, 1'b0, "flush_wr_commit"); push_exp(d, 1, 64'h66, 1'b0, "flush9"); tick();

    // Mid-operation reset: immediate clear, same-cycle write and issue discarded.
    idle(); issue(d, 2); tick();
    idle(); wr(d, 0, 13, 64'h99); issue(d, 14); rd(d, 0, 13); rd(d, 1, 5); nRST = 1'b0;
    push_exp(d, 0, 64'h0, 1'b0, "rst_no_bypass"); push_exp(d, 1, 64'h0, 1'b0, "rst_clears_now"); tick();
    idle(); nRST = 1'b1; rd(d, 0, 13); rd(d, 1, 14);
    push_exp(d, 0, 64'h0, 1'b0, "rst_wr_dropped"); push_exp(d, 1, 64'h0, 1'b0, "rst_issue_dropped"); tick();
    idle(); rd(d, 0, 2); push_exp(d, 0, 64'h0, 1'b0, "rst_pend_cleared"); tick();
  endtask

  initial begin
    idle();
    nRST = 1'b0;
    #2;
    // Activity during reset must not show through or commit.
    wr(0, 0, 5, 64'h1111); wr(1, 0, 5, 64'h1111); issue(0, 6); issue(1, 6);
    rd(0, 0, 5); rd(1, 0, 5);
    push_exp(0, 0, 64'h0, 1'b0, "in_reset"); push_exp(1, 0, 64'h0, 1'b0, "in_reset");
    tick();
    tick();
    idle();
    nRST = 1'b1;

    for (int r = 0; r < 32; r++) begin
      idle();
      rd(0, 0, r); rd(0, 1, 31 - r);
      push_exp(0, 0, 64'h0, 1'b0, "reset_scan"); push_exp(0, 1, 64'h0, 1'b0, "reset_scan");
      if (r < 16) begin
        rd(1, 0, r); rd(1, 1, 15 - r); rd(1, 2, r);
        push_exp(1, 0, 64'h0, 1'b0, "reset_scan");
        push_exp(1, 1, 64'h0, 1'b0, "reset_scan");
        push_exp(1, 2, 64'h0, 1'b0, "reset_scan");
      end
      tick();
    end

    for (int d = 0; d < 2; d++) begin
      suite(d);
    end

    idle();
    tick();
    tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
